readout_framer: RTL



---
 rtl/readout_pkg.sv | 15 +
 rtl/readout_framer_if.sv | 22 ++
 rtl/readout_fifo.sv | 51 +++++
 rtl/readout_framer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and constants for the readout framer slice.
package readout_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECKSUM
  } framer_state_t;

  localparam byte_t SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/readout_framer_if.sv
// Sample-in and framed-byte-out handshake bundle for readout_framer.
interface readout_framer_if;
  import readout_pkg::*;

  byte_t in_data;
  logic  in_valid;
  logic  in_ready;
  byte_t out_data;
  logic  out_valid;
  logic  out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/readout_fifo.sv
// Byte FIFO with registered storage, wrapping pointers and an occupancy count.
module readout_fifo
  import readout_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  byte_t         i_data,
  input  logic          i_pop,
  output byte_t         o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/readout_framer.sv
// Frames buffered sensor bytes as SYNC, FRAME_LEN payload bytes and, when
// READOUT_FRAMER_CHECKSUM_EN is defined, an XOR trailer.
module readout_framer
  import readout_pkg::*;
#(
  parameter  int    DEPTH     = 8,
  parameter  int    FRAME_LEN = 4,
  parameter  byte_t SYNC_BYTE = SYNC_BYTE_DEFAULT,
  localparam int    LW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  readout_framer_if.slave   bus,
  output byte_t             frame_cnt,
  output logic [LW-1:0]     fifo_level
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  framer_state_t r_state;
  logic [7:0]    r_idx;
  byte_t         r_frame_cnt;
`ifdef READOUT_FRAMER_CHECKSUM_EN
  byte_t         r_csum;
`endif

  logic  w_full;
  logic  w_empty;
  logic  w_push;
  logic  w_pop;
  logic  w_accept;
  logic  w_out_valid;
  byte_t w_out_data;
  byte_t w_head;

  // rst_n term keeps in_ready low while reset is held.
  assign bus.in_ready = rst_n & ena & ~w_full;
  assign w_push       = bus.in_valid & bus.in_ready;
  assign w_accept     = w_out_valid & bus.out_ready;
  assign w_pop        = w_accept & (r_state == PAYLOAD);

  readout_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Output byte depends only on registered state, so it holds while stalled.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    case (r_state)
      HEADER: begin
        w_out_valid = ena;
        w_out_data  = SYNC_BYTE;
      end
      PAYLOAD: begin
        w_out_valid = ena & ~w_empty;
        w_out_data  = w_head;
      end
`ifdef READOUT_FRAMER_CHECKSUM_EN
      CHECKSUM: begin
        w_out_valid = ena;
        w_out_data  = r_csum;
      end
`endif
      default: begin
        w_out_valid = 1'b0;
        w_out_data  = '0;
      end
    endcase
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign frame_cnt     = r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_frame_cnt <= '0;
`ifdef READOUT_FRAMER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          if (!w_empty) r_state <= HEADER;
        end
        HEADER: begin
          if (w_accept) begin
            r_idx   <= '0;
            r_state <= PAYLOAD;
`ifdef READOUT_FRAMER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        PAYLOAD: begin
          if (w_accept) begin
            r_idx <= r_idx + 8'd1;
`ifdef READOUT_FRAMER_CHECKSUM_EN
            r_csum <= r_csum ^ w_head;
            if (r_idx == LAST_IDX) r_state <= CHECKSUM;
`else
            if (r_idx == LAST_IDX) begin
              r_state     <= IDLE;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
`endif
          end
        end
`ifdef READOUT_FRAMER_CHECKSUM_EN
        CHECKSUM: begin
          if (w_accept) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_state     <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
